// File: rtl/feedback_delay_reverb.sv
// Single-channel feedback-comb reverb: w[n]=x[n]+fb*w[n-D], y[n]=dry*x[n]+wet*w[n-D].
// Delay line lives in an inferred RAM that is zeroed after every reset/disable.
module feedback_delay_reverb #(
  parameter int G_DATA_WIDTH       = 16,
  parameter int G_DELAY_DEPTH_LOG2 = 10,
  parameter int G_GAIN_WIDTH       = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic                                 bypass,
  input  logic        [G_DELAY_DEPTH_LOG2-1:0] delay_len,
  input  logic        [G_GAIN_WIDTH-1:0]       feedback_gain,
  input  logic        [G_GAIN_WIDTH-1:0]       wet_gain,
  input  logic        [G_GAIN_WIDTH-1:0]       dry_gain,
  input  logic signed [G_DATA_WIDTH-1:0]       din,
  input  logic                                 din_valid,
  output logic                                 din_ready,
  output logic signed [G_DATA_WIDTH-1:0]       dout,
  output logic                                 dout_valid,
  input  logic                                 dout_ready,
  output logic                                 clear_busy,
  output logic                                 clip
);

  localparam int DW = G_DATA_WIDTH;
  localparam int AW = G_DELAY_DEPTH_LOG2;
  localparam int GW = G_GAIN_WIDTH;
  localparam int PW = DW + GW + 1;
  localparam int SW = PW + 1;
  localparam int SH = GW - 1;
  localparam int DEPTH = 1 << AW;

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_RD,
    S_CALC,
    S_OUT
  } state_t;

  state_t               state_q;
  logic [AW-1:0]        clr_addr_q;
  logic [AW-1:0]        wptr_q;
  logic [AW-1:0]        raddr_q;
  logic [AW-1:0]        delay_eff;
  logic signed [DW-1:0] x_q;
  logic signed [DW-1:0] rd_q;
  logic signed [DW-1:0] dout_q;
  logic [GW-1:0]        fb_q;
  logic [GW-1:0]        wet_q;
  logic [GW-1:0]        dry_q;
  logic                 byp_q;
  logic                 dout_valid_q;
  logic                 din_ready_q;
  logic                 clip_q;
  logic                 clear_busy_q;
  logic                 run;

  logic signed [DW-1:0] mem [0:DEPTH-1];

  logic                 we_d;
  logic [AW-1:0]        waddr_d;
  logic signed [DW-1:0] wdata_d;

  logic signed [PW-1:0] d_ext, x_ext, fb_ext, wet_ext, dry_ext;
  logic signed [PW-1:0] prod_fb, prod_wet, prod_dry;
  logic signed [SW-1:0] w_sum, y_sum;
  logic signed [DW-1:0] w_d, y_d;
  logic                 w_ovf, y_ovf;

  function automatic logic signed [DW-1:0] sat_f(input logic signed [SW-1:0] v);
    if (v > SAT_MAX)      sat_f = SAT_MAX[DW-1:0];
    else if (v < SAT_MIN) sat_f = SAT_MIN[DW-1:0];
    else                  sat_f = v[DW-1:0];
  endfunction

  function automatic logic ovf_f(input logic signed [SW-1:0] v);
    ovf_f = (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  assign run       = enable && !reset;
  assign delay_eff = (delay_len == '0) ? AW'(1) : delay_len;

  // Gains are unsigned, so zero-extend before the signed multiply.
  always_comb begin
    d_ext    = PW'(rd_q);
    x_ext    = PW'(x_q);
    fb_ext   = PW'($signed({1'b0, fb_q}));
    wet_ext  = PW'($signed({1'b0, wet_q}));
    dry_ext  = PW'($signed({1'b0, dry_q}));
    prod_fb  = fb_ext * d_ext;
    prod_wet = wet_ext * d_ext;
    prod_dry = dry_ext * x_ext;
    w_sum    = SW'(x_q) + SW'(prod_fb >>> SH);
    y_sum    = (SW'(prod_dry) + SW'(prod_wet)) >>> SH;
    w_d      = sat_f(w_sum);
    y_d      = sat_f(y_sum);
    w_ovf    = ovf_f(w_sum);
    y_ovf    = ovf_f(y_sum);
  end

  always_comb begin
    we_d    = 1'b0;
    waddr_d = clr_addr_q;
    wdata_d = '0;
    if (run) begin
      if (state_q == S_CLEAR) begin
        we_d = 1'b1;
      end else if (state_q == S_CALC && !byp_q) begin
        we_d    = 1'b1;
        waddr_d = wptr_q;
        wdata_d = w_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we_d) mem[waddr_d] <= wdata_d;
    rd_q <= mem[raddr_q];
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state_q      <= S_CLEAR;
      clr_addr_q   <= '0;
      wptr_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      din_ready_q  <= 1'b0;
      clip_q       <= 1'b0;
      clear_busy_q <= 1'b1;
    end else begin
      case (state_q)
        S_CLEAR: begin
          clr_addr_q <= clr_addr_q + AW'(1);
          if (clr_addr_q == '1) begin
            state_q      <= S_IDLE;
            clear_busy_q <= 1'b0;
            din_ready_q  <= 1'b1;
          end
        end
        S_IDLE: begin
          if (din_valid) begin
            x_q         <= din;
            fb_q        <= feedback_gain;
            wet_q       <= wet_gain;
            dry_q       <= dry_gain;
            byp_q       <= bypass;
            raddr_q     <= wptr_q - delay_eff;
            din_ready_q <= 1'b0;
            state_q     <= S_RD;
          end
        end
        S_RD: state_q <= S_CALC;
        S_CALC: begin
          if (byp_q) begin
            dout_q <= x_q;
          end else begin
            dout_q <= y_d;
            wptr_q <= wptr_q + AW'(1);
            if (w_ovf || y_ovf) clip_q <= 1'b1;
          end
          dout_valid_q <= 1'b1;
          state_q      <= S_OUT;
        end
        S_OUT: begin
          if (dout_ready) begin
            dout_valid_q <= 1'b0;
            din_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign din_ready  = din_ready_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign clear_busy = clear_busy_q;
  assign clip       = clip_q;

endmodule

// File: tb/tb_feedback_delay_reverb.sv
// Scoreboard bench for feedback_delay_reverb: a history-based reference model
// predicts each output at acceptance; a monitor checks outputs as they appear.
module tb_feedback_delay_reverb;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int GW    = 16;
  localparam int DEPTH = 1 << AW;
  localparam int SH    = GW - 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 bypass;
  logic [AW-1:0]        delay_len;
  logic [GW-1:0]        feedback_gain;
  logic [GW-1:0]        wet_gain;
  logic [GW-1:0]        dry_gain;
  logic signed [DW-1:0] din;
  logic                 din_valid;
  logic                 din_ready;
  logic signed [DW-1:0] dout;
  logic                 dout_valid;
  logic                 dout_ready;
  logic                 clear_busy;
  logic                 clip;

  always #5 clk = ~clk;

  feedback_delay_reverb #(
    .G_DATA_WIDTH      (DW),
    .G_DELAY_DEPTH_LOG2(AW),
    .G_GAIN_WIDTH      (GW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .bypass       (bypass),
    .delay_len    (delay_len),
    .feedback_gain(feedback_gain),
    .wet_gain     (wet_gain),
    .dry_gain     (dry_gain),
    .din          (din),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .clear_busy   (clear_busy),
    .clip         (clip)
  );

  typedef struct {
    int val;
    bit clp;
  } exp_t;

  exp_t exp_q[$];
  int   w_hist[$];
  bit   m_clip;
  int   ready_mode;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int clamp(input longint v);
    if (v > 32767) begin
      m_clip = 1'b1;
      return 32767;
    end
    if (v < -32768) begin
      m_clip = 1'b1;
      return -32768;
    end
    return int'(v);
  endfunction

  // w history holds every w written since the last clear; w[n-D] is absent -> 0.
  function automatic int model(input int x, input int dl, input int fb, input int wet,
                               input int dry, input bit byp);
    int     deff, n, d;
    longint wv, yv;
    if (byp) return x;
    deff = (dl == 0) ? 1 : dl;
    n    = w_hist.size();
    d    = (n >= deff) ? w_hist[n - deff] : 0;
    wv   = longint'(x) + ((longint'(fb) * d) >>> SH);
    yv   = (longint'(dry) * x + longint'(wet) * d) >>> SH;
    w_hist.push_back(clamp(wv));
    return clamp(yv);
  endfunction

  function automatic int rand_s16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic send(input int x, input int dl, input int fb, input int wet, input int dry,
                      input bit byp, input bit use_tab = 1'b0, input int tab = 0);
    exp_t e;
    int   y;
    int   n;
    @(negedge clk);
    din           = DW'(x);
    delay_len     = AW'(dl);
    feedback_gain = GW'(fb);
    wet_gain      = GW'(wet);
    dry_gain      = GW'(dry);
    bypass        = byp;
    din_valid     = 1'b1;
    n = 0;
    while (!din_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!din_ready) begin
      check("din_ready_timeout", 0, 1);
      din_valid = 1'b0;
      return;
    end
    y     = model(x, dl, fb, wet, dry, byp);
    e.val = use_tab ? tab : y;
    e.clp = m_clip;
    exp_q.push_back(e);
    @(posedge clk);
    #1 din_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic do_clear(input bit via_enable);
    int bad = 0;
    if (via_enable) enable = 1'b0;
    else            reset  = 1'b1;
    exp_q.delete();
    w_hist.delete();
    m_clip = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_clear_busy", clear_busy, 1);
    check("rst_din_ready", din_ready, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_clip", clip, 0);
    reset  = 1'b0;
    enable = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      @(negedge clk);
      if (clear_busy !== 1'b1 || din_ready !== 1'b0 || dout_valid !== 1'b0) bad++;
    end
    check("clear_window_bad_cycles", bad, 0);
    @(negedge clk);
    check("clear_done_busy", clear_busy, 0);
    check("clear_done_ready", din_ready, 1);
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       dout_ready = 1'($urandom_range(0, 1));
      2:       dout_ready = 1'b0;
      default: dout_ready = 1'b1;
    endcase
  end

  bit                   stalled = 1'b0;
  logic signed [DW-1:0] held;

  always @(negedge clk) begin
    exp_t e;
    if (dout_valid) begin
      check("din_ready_during_out", din_ready, 0);
      if (stalled) check("dout_stable", dout, held);
      if (dout_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_dout", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("dout", dout, e.val);
          check("clip", clip, e.clp);
        end
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = dout;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int echo_tab[13];
    int cx[4];
    int ct[4];
    int x0, x1, xv, tab;
    echo_tab = '{0, 0, 0, 0, 1000, 0, 0, 0, 500, 0, 0, 0, 250};
    cx = '{30000, 30000, -30000, -30000};
    ct = '{30000, 32767, 0, -32768};
    reset = 1'b0; enable = 1'b1; bypass = 1'b0; delay_len = '0;
    feedback_gain = '0; wet_gain = '0; dry_gain = '0;
    din = '0; din_valid = 1'b0; dout_ready = 1'b1; ready_mode = 0;

    do_clear(1'b0);

    for (int i = 0; i < 13; i++)
      send((i == 0) ? 1000 : 0, 4, 'h4000, 'h8000, 0, 1'b0, 1'b1, echo_tab[i]);
    drain();

    do_clear(1'b0);
    for (int i = 0; i < 4; i++)
      send(cx[i], 1, 0, 'h8000, 'h8000, 1'b0, 1'b1, ct[i]);
    drain();
    check("clip_sticky", clip, 1);

    do_clear(1'b0);
    for (int i = 0; i < 20; i++)
      send(rand_s16(), int'($urandom_range(0, 1)), int'($urandom_range(0, 'h8000)),
           int'($urandom_range(0, 'h8000)), int'($urandom_range(0, 'h8000)), 1'b0);
    drain();

    ready_mode = 2;
    send(1234, 2, 'h4000, 'h8000, 'h8000, 1'b0);
    repeat (4) @(negedge clk);
    check("stall_valid_held", dout_valid, 1);
    repeat (8) @(negedge clk);
    check("stall_no_accept", din_ready, 0);
    ready_mode = 0;
    drain();

    do_clear(1'b0);
    x0 = rand_s16();
    x1 = rand_s16();
    for (int i = 0; i <= DEPTH; i++) begin
      xv  = (i == 0) ? x0 : (i == 1) ? x1 : rand_s16();
      tab = (i == DEPTH - 1) ? x0 : (i == DEPTH) ? x1 : 0;
      send(xv, DEPTH - 1, 0, 'h8000, 0, 1'b0, 1'b1, tab);
    end
    drain();

    do_clear(1'b0);
    for (int i = 0; i < 5; i++)  send(rand_s16() / 2, 3, 'h6000, 'h8000, 'h8000, 1'b0);
    for (int i = 0; i < 5; i++)  send(rand_s16(), 3, 'h6000, 'h8000, 'h8000, 1'b1);
    for (int i = 0; i < 10; i++) send(0, 3, 'h6000, 'h8000, 'h8000, 1'b0);
    drain();

    ready_mode = 1;
    for (int i = 0; i < 100; i++)
      send(rand_s16(), int'($urandom_range(1, 16)), int'($urandom_range(0, 'hFFFF)),
           int'($urandom_range(0, 'hFFFF)), int'($urandom_range(0, 'hFFFF)),
           ($urandom_range(0, 7) == 0));
    drain();
    ready_mode = 0;

    send(500, 1, 0, 'h8000, 'h8000, 1'b0);
    do_clear(1'b1);
    for (int i = 0; i < 4; i++) send(100 * (i + 1), 2, 'h8000, 'h8000, 'h4000, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
